sic1_host_loader: RTL and testbench

//  Host-side driver for the SIC-1 core's halt-mode load/run interface; the initiator that core expects.

---
 rtl/sic1_host_loader.sv | 218 +++++++++++++++++++++
 tb/tb_sic1_host_loader.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sic1_host_loader.sv
// sic1_host_loader: host-side initiator for the SIC-1 core's halt-mode
// load/run interface. It takes a program as a byte stream, writes it into
// core memory through set_pc/set_data strobes, points the core at the exec
// PC, raises run and waits for the core to halt again.
// Optional feature macro: SIC1_LOADER_WDT_EN adds an execution watchdog that
// aborts a run after WDT_CYCLES cycles; without it timeout is tied low.
module sic1_host_loader
`ifdef SIC1_LOADER_WDT_EN
#(
  parameter int WDT_CYCLES = 65535,
  parameter int WDT_W      = 16
)
`endif
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] load_addr,
  input  logic [8:0] load_len,
  input  logic [7:0] exec_pc,
  input  logic       s_valid,
  input  logic [7:0] s_data,
  output logic       s_ready,
  output logic [7:0] cpu_ui,
  output logic       cpu_run,
  output logic       cpu_set_pc,
  output logic       cpu_set_data,
  input  logic       cpu_halted,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       timeout
);

  typedef enum logic [3:0] {
    S_IDLE, S_SET_LA, S_GAP, S_FETCH, S_WRITE,
    S_SET_EX, S_RUN_WAIT_LO, S_RUN_WAIT_HI, S_DONE
  } state_t;

  state_t     state_q, state_d;
  state_t     gap_nxt_q, gap_nxt_d;   // where the GAP state goes next
  logic [8:0] rem_q, rem_d;           // bytes still to fetch
  logic [7:0] ex_q, ex_d;             // latched exec PC
  logic [7:0] cpu_ui_q, cpu_ui_d;
  logic       run_q, run_d;
  logic       set_pc_q, set_pc_d;
  logic       set_data_q, set_data_d;
  logic       s_ready_q, s_ready_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       err_q, err_d;

`ifdef SIC1_LOADER_WDT_EN
  localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);
  logic [WDT_W-1:0] wdt_q, wdt_d;
  logic             timeout_q, timeout_d;
  logic             wdt_hit;
  assign wdt_hit = (wdt_q == WDT_LAST);
`endif

  // Next-state and next-output logic; every output is registered from state_d.
  always_comb begin
    state_d   = state_q;
    gap_nxt_d = gap_nxt_q;
    rem_d     = rem_q;
    ex_d      = ex_q;
    cpu_ui_d  = cpu_ui_q;
    err_d     = err_q;
`ifdef SIC1_LOADER_WDT_EN
    timeout_d = timeout_q;
`endif

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          rem_d = load_len;
          ex_d  = exec_pc;
          err_d = 1'b0;
`ifdef SIC1_LOADER_WDT_EN
          timeout_d = 1'b0;
`endif
          // Refuse an exec PC the core cannot run from, or a core that is
          // not parked in halt mode; no strobe is ever issued in that case.
          if ((exec_pc > 8'd252) || !cpu_halted) begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end else if (load_len != 9'd0) begin
            state_d   = S_SET_LA;
            cpu_ui_d  = load_addr;
            gap_nxt_d = S_FETCH;
          end else begin
            state_d   = S_SET_EX;
            cpu_ui_d  = exec_pc;
            gap_nxt_d = S_RUN_WAIT_LO;
          end
        end
      end
      S_SET_LA: state_d = S_GAP;
      S_GAP: begin
        state_d = gap_nxt_q;
        if (gap_nxt_q == S_SET_EX) begin
          cpu_ui_d  = ex_q;
          gap_nxt_d = S_RUN_WAIT_LO;
        end
      end
      S_FETCH: begin
        if (s_valid && s_ready_q) begin
          cpu_ui_d = s_data;
          rem_d    = rem_q - 9'd1;
          state_d  = S_WRITE;
        end
      end
      S_WRITE: begin
        state_d   = S_GAP;
        gap_nxt_d = (rem_q != 9'd0) ? S_FETCH : S_SET_EX;
      end
      S_SET_EX: state_d = S_GAP;
      S_RUN_WAIT_LO: begin
`ifdef SIC1_LOADER_WDT_EN
        if (wdt_hit) begin
          state_d   = S_DONE;
          err_d     = 1'b1;
          timeout_d = 1'b1;
        end else
`endif
        if (!cpu_halted) state_d = S_RUN_WAIT_HI;
      end
      S_RUN_WAIT_HI: begin
        // A halt seen in the same cycle as watchdog expiry counts as success.
        if (cpu_halted) begin
          state_d = S_DONE;
          err_d   = 1'b0;
        end
`ifdef SIC1_LOADER_WDT_EN
        else if (wdt_hit) begin
          state_d   = S_DONE;
          err_d     = 1'b1;
          timeout_d = 1'b1;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_DONE) cpu_ui_d = 8'd0;

    set_pc_d   = (state_d == S_SET_LA) || (state_d == S_SET_EX);
    set_data_d = (state_d == S_WRITE);
    run_d      = (state_d == S_RUN_WAIT_LO) || (state_d == S_RUN_WAIT_HI);
    s_ready_d  = (state_d == S_FETCH);
    busy_d     = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d     = (state_d == S_DONE);

`ifdef SIC1_LOADER_WDT_EN
    // Restart the budget on every entry into the run phase.
    if ((state_d == S_RUN_WAIT_LO) && (state_q != S_RUN_WAIT_LO))
      wdt_d = '0;
    else if ((state_q == S_RUN_WAIT_LO) || (state_q == S_RUN_WAIT_HI))
      wdt_d = wdt_q + WDT_W'(1);
    else
      wdt_d = wdt_q;
`endif
  end

  // State, latched fields and registered outputs; reset drops strobes at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      gap_nxt_q  <= S_IDLE;
      rem_q      <= '0;
      ex_q       <= '0;
      cpu_ui_q   <= '0;
      run_q      <= 1'b0;
      set_pc_q   <= 1'b0;
      set_data_q <= 1'b0;
      s_ready_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef SIC1_LOADER_WDT_EN
      wdt_q      <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      gap_nxt_q  <= gap_nxt_d;
      rem_q      <= rem_d;
      ex_q       <= ex_d;
      cpu_ui_q   <= cpu_ui_d;
      run_q      <= run_d;
      set_pc_q   <= set_pc_d;
      set_data_q <= set_data_d;
      s_ready_q  <= s_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
`ifdef SIC1_LOADER_WDT_EN
      wdt_q      <= wdt_d;
      timeout_q  <= timeout_d;
`endif
    end
  end

  assign s_ready      = s_ready_q;
  assign cpu_ui       = cpu_ui_q;
  assign cpu_run      = run_q;
  assign cpu_set_pc   = set_pc_q;
  assign cpu_set_data = set_data_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
`ifdef SIC1_LOADER_WDT_EN
  assign timeout      = timeout_q;
`else
  assign timeout      = 1'b0;
`endif

endmodule

// File: tb/tb_sic1_host_loader.sv
// Testbench for sic1_host_loader: a behavioural SIC-1 core model, a byte
// source with an optional stall pattern, and a scoreboard of expected
// strobe/run events checked as the loader produces them.
module tb_sic1_host_loader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] load_addr = '0;
  logic [8:0] load_len = '0;
  logic [7:0] exec_pc = '0;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = '0;
  logic       s_ready;
  logic [7:0] cpu_ui;
  logic       cpu_run, cpu_set_pc, cpu_set_data;
  logic       cpu_halted;
  logic       busy, done, err, timeout;

  always #5 clk = ~clk;

`ifdef SIC1_LOADER_WDT_EN
  localparam int WDT_N = 100;
  sic1_host_loader #(.WDT_CYCLES(WDT_N), .WDT_W(16)) u_dut (
`else
  sic1_host_loader u_dut (
`endif
    .clk(clk), .rst_n(rst_n), .start(start), .load_addr(load_addr),
    .load_len(load_len), .exec_pc(exec_pc), .s_valid(s_valid),
    .s_data(s_data), .s_ready(s_ready), .cpu_ui(cpu_ui), .cpu_run(cpu_run),
    .cpu_set_pc(cpu_set_pc), .cpu_set_data(cpu_set_data),
    .cpu_halted(cpu_halted), .busy(busy), .done(done), .err(err),
    .timeout(timeout)
  );

  int n_total = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- core model ----------------
  logic [7:0] mem [0:255];
  logic [7:0] core_pc = '0;
  logic [7:0] pc_after_data = '0;
  logic       core_halted = 1'b1;
  logic       run_d1 = 1'b0;
  int         run_cnt = 0;
  bit         loop_mode = 1'b0;

  assign cpu_halted = core_halted;

  initial for (int i = 0; i < 256; i++) mem[i] = 8'h00;

  always @(posedge clk) begin
    run_d1 <= cpu_run;
    if (cpu_set_pc) core_pc <= cpu_ui;
    if (cpu_set_data) begin
      mem[core_pc]  <= cpu_ui;
      core_pc       <= 8'(core_pc + 8'd1);
      pc_after_data <= 8'(core_pc + 8'd1);
    end
    if (cpu_run && !run_d1 && core_halted) begin
      core_halted <= 1'b0;
      run_cnt     <= 0;
    end else if (!core_halted) begin
      run_cnt <= run_cnt + 1;
      if (!cpu_run) core_halted <= 1'b1;
      else if (!loop_mode && run_cnt == 7) core_halted <= 1'b1;
    end
  end

  // ---------------- byte source ----------------
  logic [7:0] src_q[$];
  logic [7:0] pgm[$];
  bit         stall_mode = 1'b0;
  int         cyc = 0;
  int         consumed = 0;
  logic       hs = 1'b0;

  always @(posedge clk) begin
    hs  <= s_valid && s_ready;
    cyc <= cyc + 1;
  end

  initial begin
    forever begin
      @(negedge clk);
      if (hs && src_q.size() > 0) begin
        void'(src_q.pop_front());
        consumed++;
      end
      s_valid = (src_q.size() > 0) && (!stall_mode || (cyc % 4 == 0));
      s_data  = (src_q.size() > 0) ? src_q[0] : 8'h00;
    end
  end

  // ---------------- scoreboard monitor ----------------
  // event encoding: {kind, value}; kind 1 = set_pc, 2 = set_data, 3 = run rise
  logic [9:0] exp_q[$];
  int         last_run_len = 0;

  initial begin
    logic       prev_strb;
    logic       run_prev;
    int         run_len;
    logic [9:0] obs;
    logic [9:0] want;
    bit         ev;
    prev_strb = 1'b0;
    run_prev  = 1'b0;
    run_len   = 0;
    forever begin
      @(negedge clk);
      ev  = 1'b1;
      obs = '0;
      if (cpu_set_pc)                obs = {2'd1, cpu_ui};
      else if (cpu_set_data)         obs = {2'd2, cpu_ui};
      else if (cpu_run && !run_prev) obs = {2'd3, 8'h00};
      else                           ev = 1'b0;
      if (cpu_set_pc || cpu_set_data) chk("strobe_gap", 32'(prev_strb), 32'd0);
      if (ev) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected", 32'(obs), 32'd0);
        end else begin
          want = exp_q.pop_front();
          chk("sb_event", 32'(obs), 32'(want));
        end
      end
      if (cpu_run) run_len++;
      else if (run_prev) begin
        last_run_len = run_len;
        run_len = 0;
      end
      prev_strb = cpu_set_pc | cpu_set_data;
      run_prev  = cpu_run;
    end
  end

  // ---------------- helpers ----------------
  task automatic start_sess(input logic [7:0] la, input logic [8:0] len,
                            input logic [7:0] ex, input int supply);
    @(negedge clk);
    if (ex <= 8'd252 && cpu_halted) begin
      if (len != 9'd0) begin
        exp_q.push_back({2'd1, la});
        for (int i = 0; i < pgm.size(); i++) exp_q.push_back({2'd2, pgm[i]});
      end
      exp_q.push_back({2'd1, ex});
      exp_q.push_back({2'd3, 8'h00});
    end
    for (int i = 0; i < supply; i++) src_q.push_back(pgm[i]);
    start = 1'b1;
    load_addr = la;
    load_len = len;
    exec_pc = ex;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && !done; i++) @(negedge clk);
    chk("wait_done", 32'(done), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "global timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    int c0;
    logic [7:0] b;

    // Reset state
    @(negedge clk);
    chk("rst_outputs", 32'({cpu_ui, cpu_run, cpu_set_pc, cpu_set_data, s_ready,
                            busy, done, err, timeout}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);

    // 1: three-byte load and run
    pgm = '{8'h20, 8'h21, 8'h00};
    start_sess(8'h10, 9'd3, 8'h10, 3);
    chk("t1_busy", 32'(busy), 32'd1);
    wait_done(300);
    chk("t1_err", 32'(err), 32'd0);
    chk("t1_timeout", 32'(timeout), 32'd0);
    chk("t1_busy_done", 32'(busy), 32'd0);
    chk("t1_mem10", 32'(mem[8'h10]), 32'h20);
    chk("t1_mem11", 32'(mem[8'h11]), 32'h21);
    chk("t1_mem12", 32'(mem[8'h12]), 32'h00);
    chk("t1_ui_run_idle", 32'({cpu_ui, cpu_run}), 32'd0);
    chk("t1_drain", 32'(exp_q.size()), 32'd0);

    // 2: exec_pc beyond 252 is refused the next cycle
    pgm.delete();
    start_sess(8'h00, 9'd0, 8'd253, 0);
    chk("t2_done", 32'(done), 32'd1);
    chk("t2_err", 32'(err), 32'd1);
    chk("t2_busy", 32'(busy), 32'd0);
    repeat (6) @(negedge clk);
    chk("t2_run", 32'(cpu_run), 32'd0);
    chk("t2_drain", 32'(exp_q.size()), 32'd0);

    // 3: stalling source, valid 1 cycle in 4
    pgm.delete();
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom_range(1, 255));
      pgm.push_back(b);
    end
    stall_mode = 1'b1;
    c0 = consumed;
    start_sess(8'h80, 9'd4, 8'h80, 4);
    wait_done(500);
    stall_mode = 1'b0;
    chk("t3_consumed", 32'(consumed - c0), 32'd4);
    for (int i = 0; i < 4; i++) chk("t3_mem", 32'(mem[8'h80 + i]), 32'(pgm[i]));
    chk("t3_err", 32'(err), 32'd0);
    chk("t3_drain", 32'(exp_q.size()), 32'd0);

    // 4: address wrap past 0xFF, exec_pc at the 252 limit
    pgm = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    start_sess(8'hFE, 9'd4, 8'd252, 4);
    wait_done(300);
    chk("t4_err", 32'(err), 32'd0);
    chk("t4_pc_wrap", 32'(pc_after_data), 32'h02);
    chk("t4_memFE", 32'(mem[8'hFE]), 32'hA1);
    chk("t4_memFF", 32'(mem[8'hFF]), 32'hA2);
    chk("t4_mem00", 32'(mem[8'h00]), 32'hA3);
    chk("t4_mem01", 32'(mem[8'h01]), 32'hA4);
    chk("t4_drain", 32'(exp_q.size()), 32'd0);

`ifdef SIC1_LOADER_WDT_EN
    // 5: self-looping program aborted by the watchdog
    pgm.delete();
    loop_mode = 1'b1;
    start_sess(8'h00, 9'd0, 8'h30, 0);
    wait_done(600);
    loop_mode = 1'b0;
    chk("t5_run_len", 32'(last_run_len), 32'(WDT_N));
    chk("t5_err", 32'(err), 32'd1);
    chk("t5_timeout", 32'(timeout), 32'd1);
    repeat (4) @(negedge clk);
    chk("t5_drain", 32'(exp_q.size()), 32'd0);
`endif

    // 6: reset while fetching byte 2, then a run-only session
    pgm = '{8'h11, 8'h22, 8'h33};
    start_sess(8'h50, 9'd3, 8'h50, 1);
    for (int i = 0; i < 100 && !(s_ready && consumed > 0 && src_q.size() == 0); i++)
      @(negedge clk);
    chk("t6_in_fetch2", 32'(s_ready), 32'd1);
    chk("t6_ui_before", 32'(cpu_ui), 32'h11);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_rst", 32'({cpu_ui, cpu_run, cpu_set_pc, cpu_set_data, s_ready,
                             busy, done, err, timeout}), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    pgm.delete();
    start_sess(8'h00, 9'd0, 8'h40, 0);
    wait_done(300);
    chk("t6_err", 32'(err), 32'd0);
    chk("t6_core_pc", 32'(core_pc), 32'h40);
    chk("t6_drain", 32'(exp_q.size()), 32'd0);

    // start while busy is ignored: a second start mid-session changes nothing
    pgm = '{8'h5A};
    start_sess(8'hC0, 9'd1, 8'hC0, 1);
    @(negedge clk);
    start = 1'b1; load_addr = 8'h00; load_len = 9'd0; exec_pc = 8'd255;
    @(negedge clk);
    start = 1'b0;
    chk("busy_start_ignored", 32'({busy, err}), 32'b10);
    wait_done(300);
    chk("t7_err", 32'(err), 32'd0);
    chk("t7_mem", 32'(mem[8'hC0]), 32'h5A);
    chk("t7_drain", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
